md_sequencer: RTL

Multi-cycle multiply/divide controller that owns the HI/LO register pair for the two-stage MIPS core. It is started from the execute stage by MULT/MULTU/DIV/DIVU and iterates a shift-add / restoring-divide datapath over 32 cycles. It also services MFHI/MFLO/MTHI/MTLO and raises a stall to fetch whenever a HI/LO access or a new start collides with an operation in flight.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_sequencer_step.sv | 37 +++
 rtl/md_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared types for the multiply/divide sequencer.
// Optional build macro: MD_EARLY_OUT_EN (multiply early termination).
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'b00,
    MD_RUN   = 2'b01,
    MD_FIXUP = 2'b10
  } md_state_t;

  localparam int unsigned MD_ITERS = 32;

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_sequencer_step.sv
// Single combinational iteration of the multiply/divide datapath.
// Multiply: acc = {partial_hi, product_lo_bits}; ctl_bit is the current
// multiplier LSB, opnd the multiplicand; add then shift right.
// Divide (restoring): acc = {remainder, quotient}; ctl_bit is the next
// dividend bit (MSB first), opnd the divisor.
module md_step #(
  parameter int unsigned W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc_in,
  input  logic [W-1:0]   opnd,
  input  logic           ctl_bit,
  output logic [2*W-1:0] acc_out
);

  logic [W:0] mul_addend;
  logic [W:0] mul_sum;
  logic [W:0] rem_shift;
  logic [W:0] rem_diff;

  // One shift-add or restoring-subtract step
  always_comb begin
    mul_addend = ctl_bit ? {1'b0, opnd} : '0;
    mul_sum    = {1'b0, acc_in[2*W-1:W]} + mul_addend;
    rem_shift  = {acc_in[2*W-1:W], ctl_bit};
    rem_diff   = rem_shift - {1'b0, opnd};
    acc_out    = {mul_sum, acc_in[W-1:1]};
    if (is_div) begin
      if (rem_shift >= {1'b0, opnd}) begin
        acc_out = {rem_diff[W-1:0], acc_in[W-2:0], 1'b1};
      end else begin
        acc_out = {rem_shift[W-1:0], acc_in[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide controller owning the HI/LO pair.
// Optional build macro: MD_EARLY_OUT_EN -- multiply RUN ends as soon as the
// remaining multiplier bits are zero; the product is realigned in FIXUP.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned ITERS = MD_ITERS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_EX,
  input  logic [1:0]   op_EX,
  input  logic [W-1:0] a_EX,
  input  logic [W-1:0] b_EX,
  input  logic         rd_hilo_EX,
  input  logic         wr_hi_EX,
  input  logic         wr_lo_EX,
  input  logic [W-1:0] wdata_EX,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         stall_FETCH,
  output logic         done,
  output logic         div_zero
);

  localparam int unsigned CW = $clog2(ITERS + 1);

  md_state_t      state, state_nxt;
  md_op_t         op_in, op_q;
  logic [W-1:0]   op_a, op_b;
  logic [2*W-1:0] acc, acc_step, prod_aligned, prod;
  logic [CW-1:0]  count;
  logic           neg_q, neg_r, b_zero;
  logic           in_signed, in_div, is_div_q, run_last;
  logic [W-1:0]   abs_a, abs_b, step_opnd, fix_hi, fix_lo;
  logic           step_bit;
`ifdef MD_EARLY_OUT_EN
  logic [CW-1:0]  shamt;
`endif

  assign op_in    = md_op_t'(op_EX);
  assign is_div_q = md_is_div(op_q);

  md_step #(.W(W)) u_step (
    .is_div  (is_div_q),
    .acc_in  (acc),
    .opnd    (step_opnd),
    .ctl_bit (step_bit),
    .acc_out (acc_step)
  );

  // Operand conditioning at start, step operand selection and termination
  always_comb begin
    in_signed = md_is_signed(op_in);
    in_div    = md_is_div(op_in);
    abs_a     = (in_signed && a_EX[W-1]) ? (~a_EX + 1'b1) : a_EX;
    abs_b     = (in_signed && b_EX[W-1]) ? (~b_EX + 1'b1) : b_EX;
    step_opnd = is_div_q ? op_b : op_a;
    step_bit  = is_div_q ? op_a[W-1] : op_b[0];
`ifdef MD_EARLY_OUT_EN
    run_last  = (count == CW'(ITERS - 1)) || (!is_div_q && (op_b == '0));
`else
    run_last  = (count == CW'(ITERS - 1));
`endif
  end

  // Sign fixup and HI/LO result selection
  always_comb begin
`ifdef MD_EARLY_OUT_EN
    // Early exit leaves the product scaled by 2^(ITERS-count); undo it here.
    shamt        = CW'(ITERS) - count;
    prod_aligned = acc >> shamt;
`else
    prod_aligned = acc;
`endif
    prod   = neg_q ? (~prod_aligned + 1'b1) : prod_aligned;
    fix_hi = prod[2*W-1:W];
    fix_lo = prod[W-1:0];
    if (b_zero) begin
      fix_hi = neg_r ? (~op_a + 1'b1) : op_a;
      fix_lo = '1;
    end else if (is_div_q) begin
      fix_lo = neg_q ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
      fix_hi = neg_r ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
    end
  end

  // Next-state logic and status outputs
  always_comb begin
    state_nxt   = state;
    busy        = (state != MD_IDLE);
    stall_FETCH = busy & (start_EX | rd_hilo_EX | wr_hi_EX | wr_lo_EX);
    case (state)
      MD_IDLE: begin
        if (start_EX) begin
          state_nxt = (in_div && (b_EX == '0)) ? MD_FIXUP : MD_RUN;
        end
      end
      MD_RUN: begin
        if (run_last) state_nxt = MD_FIXUP;
      end
      MD_FIXUP: state_nxt = MD_IDLE;
      default:  state_nxt = MD_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MD_IDLE;
    else      state <= state_nxt;
  end

  // Datapath registers, HI/LO and completion pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= MD_MULT;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (wr_hi_EX) hi <= wdata_EX;
          if (wr_lo_EX) lo <= wdata_EX;
          if (start_EX) begin
            op_q   <= op_in;
            op_a   <= abs_a;
            op_b   <= abs_b;
            neg_q  <= in_signed & (a_EX[W-1] ^ b_EX[W-1]);
            neg_r  <= (op_in == MD_DIV) & a_EX[W-1];
            b_zero <= in_div & (b_EX == '0);
            acc    <= '0;
            count  <= '0;
          end
        end
        MD_RUN: begin
          acc   <= acc_step;
          count <= count + 1'b1;
          if (is_div_q) op_a <= op_a << 1;
          else          op_b <= op_b >> 1;
        end
        MD_FIXUP: begin
          hi       <= fix_hi;
          lo       <= fix_lo;
          done     <= 1'b1;
          div_zero <= b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule
